// File: rtl/beep_pkg.sv
// beep_seq shared types and constants.
// State encoding, widths and the C4..C5 note periods.
package beep_pkg;

  localparam int PERIOD_W = 18;
  localparam int NOTE_NUM = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  localparam logic [PERIOD_W-1:0] P_C4 = 18'd190840;
  localparam logic [PERIOD_W-1:0] P_D4 = 18'd170068;
  localparam logic [PERIOD_W-1:0] P_E4 = 18'd151515;
  localparam logic [PERIOD_W-1:0] P_F4 = 18'd143266;
  localparam logic [PERIOD_W-1:0] P_G4 = 18'd127551;
  localparam logic [PERIOD_W-1:0] P_A4 = 18'd113636;
  localparam logic [PERIOD_W-1:0] P_B4 = 18'd101214;
  localparam logic [PERIOD_W-1:0] P_C5 = 18'd95602;

endpackage

// File: rtl/beep_seq_if.sv
// Control and PWM configuration bundle of beep_seq.
// master = trigger side, slave = sequencer.
interface beep_seq_if;
  import beep_pkg::*;

  logic                start;
  logic                stop;
  logic                busy;
  logic                done;
  logic [2:0]          note_idx;
  logic [PERIOD_W-1:0] pwm_period;
  logic [PERIOD_W-1:0] pwm_duty;
  logic                pwm_en;

  modport master (
    output start, stop,
    input  busy, done, note_idx,
    input  pwm_period, pwm_duty, pwm_en
  );

  modport slave (
    input  start, stop,
    output busy, done, note_idx,
    output pwm_period, pwm_duty, pwm_en
  );

endinterface

// File: rtl/beep_note_rom.sv
// Combinational note index to PWM period lookup.
// A period of zero would mark a rest.
module beep_note_rom
  import beep_pkg::*;
(
  input  logic [2:0]          idx,
  output logic [PERIOD_W-1:0] period
);

  // Fixed melody table
  always_comb begin
    period = '0;
    unique case (idx)
      3'd0: period = P_C4;
      3'd1: period = P_D4;
      3'd2: period = P_E4;
      3'd3: period = P_F4;
      3'd4: period = P_G4;
      3'd5: period = P_A4;
      3'd6: period = P_B4;
      3'd7: period = P_C5;
    endcase
  end

endmodule

// File: rtl/beep_seq.sv
// Melody sequencer driving the PWM beeper configuration.
// BEEP_SEQ_LOOP_EN: repeat the table until stop, no done.
module beep_seq
  import beep_pkg::*;
#(
  parameter int unsigned NOTE_TICK = 15_000_000,
  parameter int unsigned GAP_TICK  = 2_500_000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       clk,
  input  logic       rst,
  beep_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] NOTE_LAST =
    CNT_W'(NOTE_TICK - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_TICK > 0 ? GAP_TICK - 1 : 0);
  localparam bit HAS_GAP = GAP_TICK > 0;

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          idx;
  logic [PERIOD_W-1:0] rom_period;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                note_end;
  logic                gap_end;
  logic                last_note;

  beep_note_rom u_rom (
    .idx    (idx),
    .period (rom_period)
  );

  assign note_end = state == PLAY &&
                    cnt == NOTE_LAST;
  assign gap_end  = state == GAP &&
                    cnt == GAP_LAST;

`ifdef BEEP_SEQ_LOOP_EN
  assign last_note = 1'b0;
`else
  assign last_note = idx == 3'd7;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.start) state_n = LOAD;
      LOAD:
        state_n = PLAY;
      PLAY:
        if (note_end) begin
          if (HAS_GAP)        state_n = GAP;
          else if (last_note) state_n = IDLE;
          else                state_n = LOAD;
        end
      GAP:
        if (gap_end) begin
          if (last_note) state_n = IDLE;
          else           state_n = LOAD;
        end
    endcase
    if (bus.stop) state_n = IDLE;
  end

  // Output next values, taken from the next state
  always_comb begin
    busy_d   = state_n != IDLE;
    done_d   = state != IDLE &&
               state_n == IDLE &&
               !bus.stop;
    period_d = period_q;
    if (state == LOAD) period_d = rom_period;
    en_d     = state_n == PLAY &&
               period_d != '0;
  end

  // Tick counter restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (state_n != state)
        cnt <= '0;
      else if (state == PLAY || state == GAP)
        cnt <= cnt + 1'b1;
      if (state == IDLE && state_n == LOAD)
        idx <= '0;
      else if (state_n == LOAD)
        idx <= idx + 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      period_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      period_q <= period_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pwm_en     = en_q;
  assign bus.note_idx   = idx;
  assign bus.pwm_period = period_q;
  assign bus.pwm_duty   = period_q >> 1;

endmodule

// File: tb/tb_beep_seq.sv
// Self-checking bench for beep_seq with short ticks.
// Define BEEP_SEQ_LOOP_EN to exercise the looping build.
module tb_beep_seq;

  localparam int NT   = 10;
  localparam int GT   = 2;
  localparam int NL   = 1 + NT + GT;
  localparam int SONG = 8 * NL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int unsigned last_period = 0;
  int unsigned tbl [8] = '{
    190840, 170068, 151515, 143266,
    127551, 113636, 101214, 95602
  };

  beep_seq_if bus ();

  beep_seq #(
    .NOTE_TICK (NT),
    .GAP_TICK  (GT),
    .CNT_W     (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    repeat ($urandom_range(0, 5)) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.pwm_en,
         bus.note_idx} !== 6'd0 ||
        bus.pwm_period !== 18'd0 ||
        bus.pwm_duty !== 18'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b en=%b idx=%0d per=%0d duty=%0d, want all 0",
        bus.busy, bus.done, bus.pwm_en,
        bus.note_idx, bus.pwm_period,
        bus.pwm_duty);
    end
    last_period = 0;
  endtask

  task automatic test_first_note();
    int hi;
    int lo;
    kick();
    n_cmp++;
    if (bus.busy !== 1'b1 ||
        bus.pwm_en !== 1'b0) begin
      n_err++;
      $display("FAIL load_latency: busy=%b en=%b, want 1 0",
        bus.busy, bus.pwm_en);
    end
    tick();
    n_cmp++;
    if (bus.pwm_en !== 1'b1 ||
        bus.pwm_period !== 18'd190840 ||
        bus.pwm_duty !== 18'd95420) begin
      n_err++;
      $display("FAIL first_note: en=%b per=%0d duty=%0d, want 1 190840 95420",
        bus.pwm_en, bus.pwm_period,
        bus.pwm_duty);
    end
    hi = 0;
    lo = 0;
    for (int t = 1; t <= NT + GT; t++) begin
      if (t <= NT && bus.pwm_en === 1'b1) hi++;
      if (t > NT && bus.pwm_en === 1'b0) lo++;
      if (t < NT + GT) tick();
    end
    n_cmp++;
    if (hi != NT || lo != GT) begin
      n_err++;
      $display("FAIL en_window: high=%0d low=%0d, want %0d %0d",
        hi, lo, NT, GT);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 ||
        bus.pwm_en !== 1'b0 ||
        bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL stop_in_gap: busy=%b en=%b done=%b, want 0 0 0",
        bus.busy, bus.pwm_en, bus.done);
    end
    last_period = tbl[0];
  endtask

  task automatic test_playback(
    input bit inject,
    input int passes
  );
    int k;
    int r;
    int unsigned ep;
    bit          ee;
    kick();
    for (int t = 0; t < passes * SONG; t++) begin
      k  = (t / NL) % 8;
      r  = t % NL;
      ee = r >= 1 && r <= NT;
      if (r != 0)      ep = tbl[k];
      else if (t == 0) ep = last_period;
      else             ep = tbl[(k + 7) % 8];
      n_cmp++;
      if (bus.busy !== 1'b1 ||
          bus.done !== 1'b0 ||
          bus.pwm_en !== ee ||
          bus.note_idx !== 3'(k) ||
          bus.pwm_period !== 18'(ep) ||
          bus.pwm_duty !== 18'(ep / 2)) begin
        n_err++;
        $display("FAIL play t=%0d: busy=%b done=%b en=%b idx=%0d per=%0d duty=%0d, want 1 0 %b %0d %0d %0d",
          t, bus.busy, bus.done, bus.pwm_en,
          bus.note_idx, bus.pwm_period,
          bus.pwm_duty, ee, k, ep, ep / 2);
      end
      bus.start = inject && t >= 1 &&
                  t <= SONG - 2 &&
                  $urandom_range(0, 2) == 0;
      tick();
      bus.start = 1'b0;
    end
    last_period = tbl[7];
  endtask

  task automatic test_song_end();
    n_cmp++;
    if (bus.busy !== 1'b0 ||
        bus.done !== 1'b1 ||
        bus.pwm_en !== 1'b0 ||
        bus.note_idx !== 3'd7 ||
        bus.pwm_period !== 18'(tbl[7])) begin
      n_err++;
      $display("FAIL song_end: busy=%b done=%b en=%b idx=%0d per=%0d, want 0 1 0 7 %0d",
        bus.busy, bus.done, bus.pwm_en,
        bus.note_idx, bus.pwm_period, tbl[7]);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: done=%b busy=%b, want 0 0",
        bus.done, bus.busy);
    end
  endtask

  task automatic test_stop();
    int at;
    int seen;
    at = 3 * NL + 1 + $urandom_range(0, NT - 1);
    kick();
    repeat (at) tick();
    n_cmp++;
    if (bus.note_idx !== 3'd3 ||
        bus.pwm_en !== 1'b1) begin
      n_err++;
      $display("FAIL stop_setup: idx=%0d en=%b, want 3 1",
        bus.note_idx, bus.pwm_en);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 ||
        bus.pwm_en !== 1'b0 ||
        bus.done !== 1'b0 ||
        bus.pwm_period !== 18'(tbl[3])) begin
      n_err++;
      $display("FAIL stop: busy=%b en=%b done=%b per=%0d, want 0 0 0 %0d",
        bus.busy, bus.pwm_en, bus.done,
        bus.pwm_period, tbl[3]);
    end
    seen = 0;
    repeat (NL + 3) begin
      tick();
      if (bus.done !== 1'b0 ||
          bus.busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL stop_quiet: %0d active cycles, want 0",
        seen);
    end
    last_period = tbl[3];
  endtask

  task automatic test_start_stop_idle();
    int seen;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus.busy !== 1'b0 ||
          bus.pwm_en !== 1'b0) seen++;
      tick();
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL start_stop_idle: %0d busy cycles, want 0",
        seen);
    end
  endtask

  task automatic test_loop_stop();
    n_cmp++;
    if (bus.busy !== 1'b1 ||
        bus.note_idx !== 3'd0 ||
        bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL loop_wrap: busy=%b idx=%0d done=%b, want 1 0 0",
        bus.busy, bus.note_idx, bus.done);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 ||
        bus.pwm_en !== 1'b0 ||
        bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL loop_stop: busy=%b en=%b done=%b, want 0 0 0",
        bus.busy, bus.pwm_en, bus.done);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    test_reset();
    test_first_note();
    test_stop();
    test_start_stop_idle();
`ifdef BEEP_SEQ_LOOP_EN
    test_playback(1'b0, 3);
    test_loop_stop();
`else
    test_playback(1'b0, 1);
    test_song_end();
    test_playback(1'b1, 1);
    test_song_end();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/beep_seq.md
# beep_seq

Melody sequencer for the PWM beeper. On `start` it steps through a fixed 8-entry note table and drives the PWM generator's period, duty and enable for each note: each note sounds for `NOTE_TICK` cycles, followed by a silent gap of `GAP_TICK` cycles. It sits between the top-level key/trigger logic and the PWM generator and is the only writer of the generator's configuration.

## Interface
- `NOTE_TICK`, 15_000_000, note duration in clk cycles (300 ms at 50 MHz); must be ≥ 1
- `GAP_TICK`, 2_500_000, silent gap after each note in clk cycles; 0 means no gap
- `CNT_W`, 24, tick counter width; must hold max(`NOTE_TICK`, `GAP_TICK`)
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  start-playback request; sampled only in IDLE
- `stop`  in  1  abort request; honoured in every state
- `busy`  out  1  high in LOAD, PLAY and GAP
- `done`  out  1  one-cycle pulse on normal completion
- `note_idx`  out  3  index of the current table entry
- `pwm_period`  out  18  PWM period in clk cycles, to the generator
- `pwm_duty`  out  18  PWM high time; always `pwm_period >> 1`
- `pwm_en`  out  1  generator enable; high only in PLAY when the entry is not a rest

## Operation
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE → LOAD when `start`=1 and `stop`=0. On this transition `note_idx` is set to 0.
- LOAD lasts 1 cycle and registers `pwm_period`/`pwm_duty` from the table entry at `note_idx`. Then → PLAY, and the tick counter clears.
- PLAY runs for `NOTE_TICK` cycles, counting 0..`NOTE_TICK`-1. At the terminal count:
  - → GAP if `GAP_TICK` > 0;
  - otherwise → next-note decision.
- GAP runs for `GAP_TICK` cycles with `pwm_en`=0, then → next-note decision.
- Next-note decision:
  - if `note_idx` < 7: increment `note_idx` and → LOAD;
  - if `note_idx` = 7: → IDLE and pulse `done` in the first IDLE cycle.
- Note table periods, in order: 190840, 170068, 151515, 143266, 127551, 113636, 101214, 95602 (C4..C5). A period of 0 is a rest: `pwm_en` stays 0 through PLAY, but timing is unchanged.
- `stop` (any non-IDLE state) → IDLE next cycle. It clears `pwm_en` and `busy`, and `done` is not pulsed.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` while busy is ignored; it does not restart playback.
- Arithmetic:
  - tick counter is unsigned `CNT_W` bits and compares against `NOTE_TICK-1` / `GAP_TICK-1`; it never wraps.
  - `note_idx` is 3 bits and wraps only under the LOOP macro.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `note_idx`=0, `pwm_period`=0, `pwm_duty`=0, `pwm_en`=0, tick counter=0.
- Latency, with `start` sampled at edge N:
  - LOAD and `busy`=1 at N+1;
  - period/duty valid and `pwm_en`=1 at N+2.
- Each note occupies 1 + `NOTE_TICK` + `GAP_TICK` cycles.
- A full song occupies 8 × (1 + `NOTE_TICK` + `GAP_TICK`) cycles from the first LOAD to IDLE.
- `pwm_period`/`pwm_duty` hold their last values in GAP and IDLE. Only `pwm_en` gates the output.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `BEEP_SEQ_LOOP_EN`
  - Defined: after note 7, `note_idx` wraps to 0 and goes to LOAD. Playback repeats until `stop`, and `done` never pulses.
  - Undefined: single pass, ending in IDLE with a `done` pulse.

## Structure
- Package `beep_pkg` holds:
  - state enum;
  - `PERIOD_W`=18 and `NOTE_NUM`=8;
  - note period constants.
- Sub-module `beep_note_rom`: combinational 3-bit index → 18-bit period lookup, instantiated once.
- The FSM and tick counter stay in `beep_seq`.

## Test plan
All tests use `NOTE_TICK`=10 and `GAP_TICK`=2.
- Reset with `rst`=1 for 3 cycles → all outputs 0, state IDLE.
- `start` pulse at cycle N → `busy`=1 at N+1; `pwm_en`=1 and `pwm_period`=190840, `pwm_duty`=95420 at N+2; `pwm_en` high for exactly 10 cycles, then low for 2.
- Full single pass → note_idx steps 0..7 and periods match the table in order. `busy` falls and `done` pulses for exactly 1 cycle 104 cycles after the first LOAD.
- `stop` asserted in the PLAY of note 3 → next cycle: IDLE, `pwm_en`=0, `busy`=0, no `done`.
- `start` during PLAY is ignored → no restart. `start`+`stop` together in IDLE → stays IDLE.
- With `BEEP_SEQ_LOOP_EN` defined → after note 7 comes note 0 with LOAD; `done` stays 0 for 3 passes; `stop` then ends playback.
